// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: binary value in over valid/ready, serial
// double-dabble to BCD, atomic display-register load, continuous digit scan.

// Single digit lane: BCD nibble to active-low segment code with blank/dash overrides.
module seg7_digit_dec (
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] code_o
);
  always_comb begin
    code_o = 7'b1111111;
    if (dash_i) begin
      code_o = 7'b1111110;
    end else if (!blank_i) begin
      case (bcd_i)
        4'd0:    code_o = 7'b0000001;
        4'd1:    code_o = 7'b1001111;
        4'd2:    code_o = 7'b0010010;
        4'd3:    code_o = 7'b0000110;
        4'd4:    code_o = 7'b1001100;
        4'd5:    code_o = 7'b0100100;
        4'd6:    code_o = 7'b0100000;
        4'd7:    code_o = 7'b0001111;
        4'd8:    code_o = 7'b0000000;
        4'd9:    code_o = 7'b0001100;
        default: code_o = 7'b1111111;
      endcase
    end
  end
endmodule

module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_WIDTH   = 14,
  parameter int SCAN_DIV    = 50000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  value_valid,
  output logic                  value_ready,
  input  logic [BIN_WIDTH-1:0]  value,
  input  logic                  blank_lz,
  output logic                  ovf,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CMP_W = (BIN_WIDTH > 32) ? BIN_WIDTH : 32;
  localparam logic [CMP_W-1:0] MAX_DEC = CMP_W'(10 ** NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_e;

  state_e                        state_q, state_d;
  logic                          ready_q, ready_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0]          shreg_q, shreg_d;
  logic [BCD_W-1:0]              bcd_q, bcd_d, bcd_adj;
  logic                          blz_q, blz_d;
  logic                          ovf_cap_q, ovf_cap_d;
  logic                          load_en;

  logic [NUM_DIGITS-1:0][6:0]    disp_q, code_nxt;
  logic                          ovf_q;
  logic [NUM_DIGITS:1]           zero_up;
  logic [NUM_DIGITS-1:0]         lane_blank;

  logic [PRE_W-1:0]              presc_q, presc_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          wrap;
  logic [NUM_DIGITS-1:0]         onehot;
  logic [6:0]                    seg_q;
  logic [NUM_DIGITS-1:0]         an_q;

  // ---------------- conversion FSM ----------------
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_adj
    assign bcd_adj[4*d +: 4] = (bcd_q[4*d +: 4] >= 4'd5) ? bcd_q[4*d +: 4] + 4'd3
                                                           : bcd_q[4*d +: 4];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    bcd_d     = bcd_q;
    blz_d     = blz_q;
    ovf_cap_d = ovf_cap_q;
    load_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (value_valid && ready_q) begin
          state_d   = CONV;
          shreg_d   = value;
          bcd_d     = '0;
          cnt_d     = CNT_W'(BIN_WIDTH - 1);
          blz_d     = blank_lz;
          ovf_cap_d = CMP_W'(value) > MAX_DEC;
        end
      end
      CONV: begin
        // Top adjusted bit falls off: only matters when the value overflows the digits.
        bcd_d   = BCD_W'({bcd_adj, shreg_q[BIN_WIDTH-1]});
        shreg_d = shreg_q << 1;
        if (cnt_q == '0) state_d = LOAD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      LOAD: begin
        state_d = IDLE;
        load_en = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      cnt_q     <= '0;
      shreg_q   <= '0;
      bcd_q     <= '0;
      blz_q     <= 1'b0;
      ovf_cap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      bcd_q     <= bcd_d;
      blz_q     <= blz_d;
      ovf_cap_q <= ovf_cap_d;
    end
  end

  // ---------------- display register ----------------
  assign zero_up[NUM_DIGITS] = 1'b1;
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_lane
    if (d == 0) begin : g_lsd
      assign lane_blank[d] = 1'b0;
    end else begin : g_msd
      if (d < NUM_DIGITS - 1) begin : g_chain
        assign zero_up[d] = zero_up[d+1] & (bcd_q[4*d +: 4] == 4'd0);
      end else begin : g_top
        assign zero_up[d] = (bcd_q[4*d +: 4] == 4'd0);
      end
      assign lane_blank[d] = blz_q & zero_up[d];
    end
    seg7_digit_dec u_dec (
      .bcd_i   (bcd_q[4*d +: 4]),
      .blank_i (lane_blank[d]),
      .dash_i  (ovf_cap_q),
      .code_o  (code_nxt[d])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_q <= {NUM_DIGITS{7'b1111111}};
      ovf_q  <= 1'b0;
    end else if (load_en) begin
      disp_q <= code_nxt;
      ovf_q  <= ovf_cap_q;
    end
  end

  // ---------------- scanning ----------------
  always_comb begin
    wrap    = (presc_q == PRE_W'(SCAN_DIV - 1));
    presc_d = wrap ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (wrap) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    onehot        = '0;
    onehot[idx_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_ACT_LOW ? 7'b1111111 : 7'b0000000;
      an_q    <= AN_ACT_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= SEG_ACT_LOW ? disp_q[idx_q] : ~disp_q[idx_q];
      an_q    <= AN_ACT_LOW ? ~onehot : onehot;
    end
  end

  assign value_ready = ready_q;
  assign ovf         = ovf_q;
  assign seg         = seg_q;
  assign an          = an_q;
endmodule
